// File: rtl/zynet_result_reader.sv
// zynet_result_reader: captures one logit vector from the network, streams it out
// one word per beat, and reports the signed argmax as the predicted class.
//   clk_i, reset_i (sync, active-low)
//   valid_i/data_i/yumi_o      : helpful-producer input vector, yumi_o consumes it
//   valid_o/ready_i/data_o/last_o : serialized logit stream
//   class_o/class_valid_o      : argmax of last completed frame, one-cycle update pulse
//   frame_count_o              : completed frames, wrapping
module zynet_result_reader #(
    parameter int WORD_SIZE   = 16,
    parameter int OUTPUT_SIZE = 10,
    parameter int CNT_BITS    = 16
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              valid_i,
    input  logic [OUTPUT_SIZE*WORD_SIZE-1:0]  data_i,
    output logic                              yumi_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [WORD_SIZE-1:0]              data_o,
    output logic                              last_o,
    output logic [$clog2(OUTPUT_SIZE)-1:0]    class_o,
    output logic                              class_valid_o,
    output logic [CNT_BITS-1:0]               frame_count_o
);
    localparam int IW = $clog2(OUTPUT_SIZE);
    localparam logic [IW-1:0] LAST = IW'(OUTPUT_SIZE - 1);

    typedef enum logic [1:0] {IDLE, SEND, REPORT} state_e;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] vec_q [OUTPUT_SIZE];
    logic [WORD_SIZE-1:0] vec_d [OUTPUT_SIZE];
    logic [IW-1:0]        idx_q, idx_d, max_idx_q, max_idx_d, class_q, class_d;
    logic [WORD_SIZE-1:0] max_val_q, max_val_d;
    logic                 class_valid_q, class_valid_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 hs;

    always_ff @(posedge clk_i) begin
        if (!reset_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = yumi_o ? SEND : IDLE;
            SEND:    state_d = (hs && last_o) ? REPORT : SEND;
            default: state_d = IDLE;
        endcase
    end

    // yumi_o is gated by reset so a frame is never consumed during a reset cycle
    always_comb begin
        yumi_o        = reset_i && state_q == IDLE && valid_i;
        valid_o       = state_q == SEND;
        data_o        = vec_q[idx_q];
        last_o        = valid_o && idx_q == LAST;
        hs            = valid_o && ready_i;
        class_o       = class_q;
        class_valid_o = class_valid_q;
        frame_count_o = cnt_q;
    end

    // word 0 seeds the running max at capture, so only idx>0 can replace it;
    // strict compare keeps the lower index on ties
    always_comb begin
        vec_d     = vec_q;
        idx_d     = idx_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        if (yumi_o) begin
            for (int k = 0; k < OUTPUT_SIZE; k++) vec_d[k] = data_i[k*WORD_SIZE +: WORD_SIZE];
            idx_d     = '0;
            max_val_d = data_i[WORD_SIZE-1:0];
            max_idx_d = '0;
        end else if (hs) begin
            idx_d = last_o ? '0 : idx_q + 1'b1;
            if (idx_q != '0 && $signed(data_o) > $signed(max_val_q)) begin
                max_val_d = data_o;
                max_idx_d = idx_q;
            end
        end
        class_valid_d = state_q == REPORT;
        class_d       = (state_q == REPORT) ? max_idx_q : class_q;
        cnt_d         = cnt_q + CNT_BITS'(state_q == REPORT);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int k = 0; k < OUTPUT_SIZE; k++) vec_q[k] <= '0;
            idx_q         <= '0;
            max_val_q     <= '0;
            max_idx_q     <= '0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            vec_q         <= vec_d;
            idx_q         <= idx_d;
            max_val_q     <= max_val_d;
            max_idx_q     <= max_idx_d;
            class_q       <= class_d;
            class_valid_q <= class_valid_d;
            cnt_q         <= cnt_d;
        end
    end
endmodule

// File: tb/tb_zynet_result_reader.sv
// tb_zynet_result_reader: table-driven frames checked through a word/class scoreboard.
module tb_zynet_result_reader;
    localparam int W  = 16;
    localparam int N  = 10;
    localparam int CB = 16;
    localparam int IW = $clog2(N);

    logic clk_i = 0, reset_i = 0, valid_i = 0, ready_i = 1;
    logic [N*W-1:0] data_i = '0;
    logic yumi_o, valid_o, last_o, class_valid_o;
    logic [W-1:0] data_o;
    logic [IW-1:0] class_o;
    logic [CB-1:0] frame_count_o;

    always #5 clk_i = ~clk_i;

    zynet_result_reader #(.WORD_SIZE(W), .OUTPUT_SIZE(N), .CNT_BITS(CB)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
        .yumi_o(yumi_o), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .last_o(last_o), .class_o(class_o), .class_valid_o(class_valid_o),
        .frame_count_o(frame_count_o)
    );

    typedef struct { logic [W-1:0] w; logic l; } beat_t;
    typedef struct { int v[N]; int mode; int cls; } vec_t;

    beat_t wq[$];
    int    cq[$];
    int    fq[$];
    vec_t  tbl[7];
    int    checks = 0, errors = 0, exp_cnt = 0, hs_cnt = 0, mode = 0;
    logic  prev_stall = 0;
    logic [W-1:0] held = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input int v[N]);
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'(v[k]);
        return r;
    endfunction

    task automatic set_row(input int i, input int v[N], input int m, input int c);
        tbl[i].v = v;
        tbl[i].mode = m;
        tbl[i].cls = c;
    endtask

    task automatic push_frame(input logic [N*W-1:0] d, input int cls);
        beat_t b;
        for (int k = 0; k < N; k++) begin
            b.w = d[k*W +: W];
            b.l = (k == N - 1);
            wq.push_back(b);
        end
        exp_cnt++;
        cq.push_back(cls);
        fq.push_back(exp_cnt % (1 << CB));
    endtask

    task automatic send_frame(input logic [N*W-1:0] d, input int cls);
        logic got = 0;
        @(posedge clk_i); #1;
        valid_i = 1;
        data_i  = d;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_i);
            if (yumi_o) got = 1;
        end
        check("yumi_seen", int'(got), 1);
        if (got) push_frame(d, cls);
        @(posedge clk_i); #1;
        valid_i = 0;
        @(negedge clk_i);
        check("first_valid_latency", int'(valid_o), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (wq.size() > 0 || cq.size() > 0); i++) @(negedge clk_i);
        check("drain_empty", wq.size() + cq.size(), 0);
        repeat (3) @(negedge clk_i);
    endtask

    initial begin
        int n, t0, base;
        set_row(0, '{5, -3, 7, 7, 0, 1, 2, 3, 4, -1}, 0, 2);
        set_row(1, '{5, -3, 7, 7, 0, 1, 2, 3, 4, -1}, 1, 2);
        set_row(2, '{5, -3, 7, 7, 0, 1, 2, 3, 4, -1}, 2, 2);
        set_row(3, '{-32768, 32767, -1, 0, 0, 0, 0, 0, 0, 0}, 0, 1);
        set_row(4, '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91}, 2, 9);
        set_row(5, '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3}, 1, 0);
        set_row(6, '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -4}, 0, 9);

        fork
            forever begin
                @(posedge clk_i); #1;
                ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? ~ready_i : 1'($urandom_range(0, 1));
            end
            forever begin
                beat_t b;
                @(negedge clk_i);
                if (reset_i) begin
                    if (prev_stall) begin
                        check("stall_valid_hold", int'(valid_o), 1);
                        check("stall_data_hold", int'(data_o), int'(held));
                    end
                    prev_stall = valid_o && !ready_i;
                    held = data_o;
                    if (valid_o && ready_i) begin
                        hs_cnt++;
                        check("word_expected", int'(wq.size() > 0), 1);
                        if (wq.size() > 0) begin
                            b = wq.pop_front();
                            check("data_o", int'(data_o), int'(b.w));
                            check("last_o", int'(last_o), int'(b.l));
                        end
                    end
                    if (class_valid_o) begin
                        check("class_pulse_expected", int'(cq.size() > 0), 1);
                        if (cq.size() > 0) begin
                            check("class_o", int'(class_o), cq.pop_front());
                            check("frame_count_o", int'(frame_count_o), fq.pop_front());
                        end
                    end
                end else prev_stall = 0;
            end
        join_none

        valid_i = 1;
        repeat (3) begin
            @(negedge clk_i);
            check("rst_yumi", int'(yumi_o), 0);
            check("rst_valid", int'(valid_o), 0);
            check("rst_class_valid", int'(class_valid_o), 0);
            check("rst_class", int'(class_o), 0);
            check("rst_count", int'(frame_count_o), 0);
        end
        @(posedge clk_i); #1;
        reset_i = 1;
        valid_i = 0;

        for (int r = 0; r < 7; r++) begin
            mode = tbl[r].mode;
            send_frame(pk(tbl[r].v), tbl[r].cls);
            drain();
        end
        mode = 0;

        // back-to-back with valid_i held high
        @(posedge clk_i); #1;
        valid_i = 1;
        data_i  = pk(tbl[0].v);
        n = 0;
        t0 = 0;
        for (int i = 0; i < 60 && n < 2; i++) begin
            @(negedge clk_i);
            if (yumi_o) begin
                push_frame(data_i, 2);
                if (n == 0) t0 = i;
                else check("frame_period", i - t0, N + 2);
                n++;
            end
        end
        check("b2b_frames", n, 2);
        @(posedge clk_i); #1;
        valid_i = 0;
        drain();

        // reset after four accepted words
        base = hs_cnt;
        send_frame(pk(tbl[3].v), 1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            if (hs_cnt >= base + 4) break;
        end
        check("mid_words", hs_cnt - base, 4);
        #1 reset_i = 0;
        @(posedge clk_i); #1;
        reset_i = 1;
        wq.delete();
        cq.delete();
        fq.delete();
        exp_cnt = 0;
        @(negedge clk_i);
        check("mid_rst_valid", int'(valid_o), 0);
        check("mid_rst_class_valid", int'(class_valid_o), 0);
        check("mid_rst_class", int'(class_o), 0);
        check("mid_rst_count", int'(frame_count_o), 0);
        repeat (15) @(negedge clk_i);
        check("mid_rst_count_hold", int'(frame_count_o), 0);
        send_frame(pk(tbl[4].v), 9);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/zynet_result_reader.md
Name: zynet_result_reader

Overview:
Consumer for the classifier's final output port. It takes one OUTPUT_SIZE-word logit vector from the network's helpful valid/yumi interface. It serializes the vector one word per beat onto a ready/valid stream and computes the signed argmax as the predicted class. It sits directly after the top-level network instance and drives that instance's yumi_i.

Parameters:
WORD_SIZE, 16, width of one signed fixed-point logit
OUTPUT_SIZE, 10, logits per frame; must be >= 2
CNT_BITS, 16, width of the completed-frame counter

Ports:
clk_i  input  1  clock; all logic on the rising edge
reset_i  input  1  synchronous, active-low reset (0 = reset)
valid_i  input  1  network result vector valid (helpful producer)
data_i  input  OUTPUT_SIZE*WORD_SIZE  logit vector; word k = data_i[k*WORD_SIZE +: WORD_SIZE]
yumi_o  output  1  demanding consume strobe to network (drives its yumi_i)
valid_o  output  1  serialized word valid
ready_i  input  1  downstream ready
data_o  output  WORD_SIZE  current serialized logit
last_o  output  1  high with word OUTPUT_SIZE-1
class_o  output  $clog2(OUTPUT_SIZE)  argmax index of last completed frame
class_valid_o  output  1  one-cycle pulse: class_o updated
frame_count_o  output  CNT_BITS  completed frames, wraps at 2^CNT_BITS

Behaviour:
- Reset (reset_i==0 at a clock edge):
  - state=IDLE; all registers cleared.
  - valid_o=0, last_o=0, class_valid_o=0, class_o=0, frame_count_o=0.
  - yumi_o=0 throughout the reset cycle.
- Reset mid-frame: captured frame is discarded with no class pulse. The upstream frame was already consumed and is not re-requested.
- FSM states:
  - IDLE:
    - yumi_o = valid_i (combinational, only in IDLE).
    - On yumi_o: register the full data_i vector, idx=0, max_val=word 0, max_idx=0, go to SEND.
  - SEND:
    - valid_o=1, data_o=vec[idx] (registered vector, mux by idx), last_o=(idx==OUTPUT_SIZE-1).
    - On valid_o&&ready_i with idx>0: if vec[idx] > max_val (signed, strict), update max_val/max_idx. Ties keep the lower index.
    - On that handshake, idx++.
    - On the handshake with last_o: next state REPORT.
  - REPORT (exactly one cycle):
    - class_o <= max_idx, registered on the REPORT edge.
    - class_valid_o=1 during the cycle after REPORT, i.e. a single-cycle pulse aligned with the new class_o.
    - frame_count_o increments in the same cycle.
    - Next state IDLE.
    - Implementation may instead pulse class_valid_o while in REPORT, provided class_o holds the final value in that cycle.
    - Required contract: class_valid_o high exactly one cycle per frame; class_o valid whenever class_valid_o=1; class_o holds until the next frame's pulse.
- yumi_o is 0 in SEND and REPORT; no new frame is captured until back in IDLE.
- Timing:
  - Capture at edge N; first valid_o at cycle N+1.
  - Full-throughput frame period = OUTPUT_SIZE+2 cycles.
- Backpressure: while valid_o && !ready_i, data_o, last_o and idx hold stable; valid_o never deasserts in SEND.
- Arithmetic: comparisons are two's-complement on WORD_SIZE bits; no saturation or scaling. data_o is bit-identical to the input word.
- Counters: idx width $clog2(OUTPUT_SIZE). frame_count_o wraps from 2^CNT_BITS-1 to 0.

Test Plan:
1. Reset: hold reset_i=0 for 3 cycles with valid_i=1 -> yumi_o=0, valid_o=0, class_valid_o=0, class_o=0, frame_count_o=0 on every cycle.
2. Single frame {5,-3,7,7,0,1,2,3,4,-1}, ready_i=1:
   - yumi_o for exactly 1 cycle.
   - data_o = 5,-3,7,...,-1 on 10 consecutive cycles; last_o only on -1.
   - class_o=2 (tie resolved to lower index), class_valid_o single pulse, frame_count_o=1.
3. Backpressure: ready_i alternating 0/1, then random at 50% -> word sequence identical to scenario 2, no drop or duplicate, data_o stable during stalls, class_o=2.
4. Signed extremes {0x8000,0x7FFF,0xFFFF,...} and all-negative frame {-100..-91} -> class_o=1 and class_o=9 respectively.
5. Back-to-back: valid_i held high, two frames, ready_i=1 -> second yumi_o in the first IDLE cycle after REPORT; period 12 cycles; frame_count_o 1 then 2.
6. Reset mid-frame after 4 accepted words -> valid_o=0 next cycle, no class_valid_o, class_o unchanged at 0, frame_count_o=0; the next frame processes normally.
